// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter: grant, hold until release, one dead cycle, re-arbitrate.
// Optional forced release after TIMEOUT_CYCLES when built with ARB_TIMEOUT_EN defined.
module rr_arb4 #(
  parameter int TIMEOUT_CYCLES = 200,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [1:0] gnt_idx,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

  state_e     state_q;
  logic [1:0] ptr_q;
  logic [1:0] gnt_idx_q;
  logic [3:0] gnt_q;
  logic       gnt_valid_q;

  // Returns {found, index}; scanning offsets high-to-low lets the nearest-to-ptr hit win.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [2:0] pick;
  logic       rel;
  logic       expire;

  assign pick = rr_pick(req, ptr_q);
  assign rel  = done[gnt_idx_q] | ~req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  assign expire  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q;
`else
  logic unused_cfg;

  assign expire     = 1'b0;
  assign timeout    = 1'b0;
  assign unused_cfg = (TIMEOUT_CYCLES != 0) ^ (CNT_W != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      gnt_idx_q   <= 2'd0;
      gnt_q       <= 4'b0000;
      gnt_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE, GAP: begin
          if (pick[2]) begin
            state_q     <= GRANT;
            gnt_idx_q   <= pick[1:0];
            gnt_q       <= 4'b0001 << pick[1:0];
            gnt_valid_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          // A genuine release on the expiry edge wins, so no timeout pulse then.
          if (rel || expire) begin
            state_q     <= GAP;
            gnt_q       <= 4'b0000;
            gnt_valid_q <= 1'b0;
            ptr_q       <= gnt_idx_q + 2'd1;
`ifdef ARB_TIMEOUT_EN
            timeout_q   <= ~rel;
`endif
          end else begin
`ifdef ARB_TIMEOUT_EN
            cnt_q <= cnt_q + CNT_W'(1);
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_idx   = gnt_idx_q;
  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: doc/rr_arb4.md
# rr_arb4

Four-way round-robin arbiter that shares one resource between requesters 0-3 and drives a 2-bit grant index into the team's 2-to-4 one-hot decoder stage (index -> one-hot LED/select). It sequences ownership: grants one requester, holds the grant until release, inserts one dead cycle, then re-arbitrates with rotating priority. It sits between the requester logic and the decoder/LED board outputs.

## Interface
Parameters:
- TIMEOUT_CYCLES, 200, maximum cycles a grant may be held before forced release; legal range 2..255, used only with ARB_TIMEOUT_EN
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous and active-low
- req  input  4  request per requester; level, held high while wanting/using the resource
- done  input  4  release strobe per requester; only the granted bit is honoured
- gnt_idx  output  2  registered index of current owner; feeds the decoder select
- gnt  output  4  registered one-hot grant; 4'b0000 when nobody owns the resource
- gnt_valid  output  1  high while a grant is active; equals |gnt
- timeout  output  1  one-cycle pulse on forced release (only with ARB_TIMEOUT_EN)

## Operation
- States: IDLE, GRANT, GAP. Reset -> IDLE.
- Reset values: gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, timeout=0, priority pointer ptr=2'd0, hold counter=0.
- IDLE: if req!=0, pick first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4); load gnt_idx, gnt=1<<idx, gnt_valid=1; go GRANT. If req==0, stay.
- GRANT: release when done[gnt_idx]=1 or req[gnt_idx]=0 (either, or both same cycle = one release). On release: gnt=0, gnt_valid=0, ptr=gnt_idx+1 (2-bit wrap, 3 -> 0), go GAP. Otherwise hold; gnt_idx unchanged.
- GAP: exactly one cycle with gnt=0; then arbitrates as IDLE does (req!=0 -> GRANT, else IDLE).
- done bits of non-granted requesters and done in IDLE/GAP are ignored.
- gnt_idx retains last owner's index while gnt=0 (decoder stage is gated by gnt_valid downstream).
- Invariant: gnt is always 0 or one-hot, and gnt==(gnt_valid ? 1<<gnt_idx : 0).

## Timing
- Grant latency: req sampled at edge N while IDLE -> gnt valid after edge N (1 cycle).
- Release latency: done/req-drop sampled at edge N -> gnt=0 after edge N.
- Back-to-back: release at edge N, GAP during cycle N..N+1, next grant after edge N+1; minimum one gnt=0 cycle between owners.
- Fairness: with all four requesting continuously, grant order 0,1,2,3,0,... ; no requester waits more than 3 other grants.
- rst_n low at any time (including mid-grant) clears all outputs immediately, asynchronously; first grant possible at the first rising edge after rst_n deasserts.

## Configuration
- ARB_TIMEOUT_EN defined: hold counter clears on entry to GRANT, increments each GRANT cycle; if release condition absent when counter reaches TIMEOUT_CYCLES-1, force release as normal (ptr advance, GAP) and pulse timeout=1 for the cycle following the release edge. Grant therefore lasts at most TIMEOUT_CYCLES cycles. Normal release on the same edge takes priority: no timeout pulse.
- ARB_TIMEOUT_EN undefined: no counter, timeout tied 0, grants held indefinitely; TIMEOUT_CYCLES and CNT_W unused.

## Test plan
- Reset: rst_n=0 mid-grant with gnt=4'b0100 -> gnt=0, gnt_valid=0, gnt_idx=0 immediately without a clock edge.
- Single request: req=4'b0100 in IDLE -> one edge later gnt=4'b0100, gnt_idx=2; done[2]=1 -> gnt=0 next edge, GAP one cycle, then IDLE.
- Round robin: req=4'b1111 held, each owner pulses done after 3 cycles -> grant sequence 0,1,2,3,0 with one gnt=0 cycle between each.
- Pointer wrap/skip: ptr=3 after owner 2, req=4'b0011 -> grant to 0, then 1 (3 empty, wraps).
- Ignored strobes: owner 1 granted, done=4'b1101 -> grant to 1 unchanged; req[1] dropped with done[1]=1 same cycle -> single release.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): req=4'b0001, never done -> gnt high exactly 4 cycles, then gnt=0 and timeout=1 for one cycle, then requester 0 re-granted after GAP.
